// File: rtl/hdmi_clk_pkg.sv
// hdmi_clk_ctrl shared types: sequencer states, output bundle and defaults.
// Output levels are a pure function of the state so they can be registered.
package hdmi_clk_pkg;

    localparam int PLL_RST_CYCLES_DEF      = 32;
    localparam int LOCK_STABLE_CYCLES_DEF  = 1024;
    localparam int LOCK_TIMEOUT_CYCLES_DEF = 65536;
    localparam int DIV_SETTLE_CYCLES_DEF   = 16;
    localparam int MAX_RETRIES_DEF         = 3;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_DIV_SETTLE,
        ST_RUN,
        ST_FAULT
    } state_e;

    typedef struct packed {
        logic pll_rst;
        logic div_rst;
        logic video_rst;
        logic ready;
        logic fault;
    } outs_t;

    function automatic int max_of(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic outs_t decode(state_e s);
        outs_t o;
        o = '{pll_rst: 1'b1, div_rst: 1'b1, video_rst: 1'b1,
              ready: 1'b0, fault: 1'b0};
        unique case (s)
            ST_PLL_RST:    ;
            ST_WAIT_LOCK:  o.pll_rst = 1'b0;
            ST_DIV_SETTLE: begin
                o.pll_rst = 1'b0;
                o.div_rst = 1'b0;
            end
            ST_RUN: begin
                o.pll_rst   = 1'b0;
                o.div_rst   = 1'b0;
                o.video_rst = 1'b0;
                o.ready     = 1'b1;
            end
            ST_FAULT:      o.fault = 1'b1;
            default:       ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a level crossing into clk_i.
// Both stages clear on the synchronous reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hdmi_clk_ctrl.sv
// HDMI clocking power-up/recovery sequencer: orders PLL, divider and video
// resets, retries lock timeouts and latches a fault after repeated failures.
module hdmi_clk_ctrl
    import hdmi_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
    parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
    parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
    parameter int DIV_SETTLE_CYCLES   = DIV_SETTLE_CYCLES_DEF,
    parameter int MAX_RETRIES         = MAX_RETRIES_DEF
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       restart,
    input  logic       locked,
    output logic       pll_rst,
    output logic       div_rst,
    output logic       video_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retries,
    output logic [7:0] lock_losses
);

    localparam int CW = $clog2(max_of(
        max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
        max_of(LOCK_TIMEOUT_CYCLES, DIV_SETTLE_CYCLES))) + 1;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] PRC_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DS_LAST  = CW'(DIV_SETTLE_CYCLES - 1);
    localparam logic [1:0]    MAXR     = 2'(MAX_RETRIES);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   stab_q, stab_d;
    logic [1:0]      retries_q, retries_d;
    logic [7:0]      losses_q, losses_d;
    outs_t           outs_q;
    logic            locked_s;
    logic            lock_loss;
    logic            enter;

    sync_2ff u_lock_sync (
        .clk_i (clk_in),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        losses_d  = losses_q;
        enter     = 1'b0;
        lock_loss = !locked_s &&
                    (state_q == ST_DIV_SETTLE || state_q == ST_RUN);
        if (restart) begin
            state_d   = ST_PLL_RST;
            retries_d = '0;
            enter     = 1'b1;
        end else if (lock_loss) begin
            state_d   = ST_PLL_RST;
            retries_d = '0;
            enter     = 1'b1;
            if (losses_q != 8'hFF) losses_d = losses_q + 8'd1;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PRC_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        enter   = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // stable completion beats a coincident timeout
                    if (locked_s && stab_q == STB_LAST) begin
                        state_d = ST_DIV_SETTLE;
                        enter   = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        enter = 1'b1;
                        if (retries_q == MAXR) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d   = ST_PLL_RST;
                            retries_d = retries_q + 2'd1;
                        end
                    end
                end
                ST_DIV_SETTLE: begin
                    if (cnt_q == DS_LAST) begin
                        state_d = ST_RUN;
                        enter   = 1'b1;
                    end
                end
                ST_RUN, ST_FAULT: ;
                default: begin
                    state_d = ST_PLL_RST;
                    enter   = 1'b1;
                end
            endcase
        end
        if (enter) cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else cnt_d = cnt_q + ONE;
        stab_d = (!enter && state_q == ST_WAIT_LOCK && locked_s) ?
                 stab_q + ONE : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            stab_q    <= '0;
            retries_q <= '0;
            losses_q  <= '0;
            outs_q    <= decode(ST_PLL_RST);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stab_q    <= stab_d;
            retries_q <= retries_d;
            losses_q  <= losses_d;
            outs_q    <= decode(state_d);
        end
    end

    assign pll_rst     = outs_q.pll_rst;
    assign div_rst     = outs_q.div_rst;
    assign video_rst   = outs_q.video_rst;
    assign ready       = outs_q.ready;
    assign fault       = outs_q.fault;
    assign retries     = retries_q;
    assign lock_losses = losses_q;

endmodule

// File: doc/hdmi_clk_ctrl.md
# hdmi_clk_ctrl

Power-up and recovery sequencer for the HDMI clocking block. It runs on the free-running 27 MHz board clock and drives the PLL reset, the serial-to-pixel clock divider reset and the video pipeline reset in a fixed order. It releases the divider only after the PLL lock is stable, and the video pipeline only after the divider has settled. It retries after lock timeouts, resequences after loss of lock, and latches a fault after repeated failures. It sits between the top-level reset and `hdmi_pll`.

## Interface
- `PLL_RST_CYCLES`, 32: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before the divider is released (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum WAIT_LOCK cycles per attempt (> `LOCK_STABLE_CYCLES`).
- `DIV_SETTLE_CYCLES`, 16: cycles between divider release and video release (≥1).
- `MAX_RETRIES`, 3: timeout retries allowed before FAULT (≥0).

Ports:
- `clk_in` in 1: 27 MHz reference clock; the only clock. Never a PLL output.
- `rst` in 1: synchronous, active-high reset.
- `restart` in 1: single-cycle request to resequence from PLL_RST; also clears FAULT.
- `locked` in 1: PLL lock, asynchronous to `clk_in`.
- `pll_rst` out 1: PLL reset, active high.
- `div_rst` out 1: clock divider reset, active high. The consumer inverts it for RESETN.
- `video_rst` out 1: video pipeline reset, active high, in the `clk_in` domain.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retries` out 2: retry count for the current sequence.
- `lock_losses` out 8: saturating count of lock losses seen in DIV_SETTLE or RUN.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Both flops clear on `rst`.
- States: PLL_RST, WAIT_LOCK, DIV_SETTLE, RUN, FAULT. All outputs are registered and decoded from the state.
- Output levels per state (`pll_rst`/`div_rst`/`video_rst`):
  - PLL_RST: 1/1/1
  - WAIT_LOCK: 0/1/1
  - DIV_SETTLE: 0/0/1
  - RUN: 0/0/0
  - FAULT: 1/1/1
- One shared cycle counter `cnt` clears on every state entry. Its width is clog2 of the largest parameter plus 1.
- WAIT_LOCK also has a stable counter `stab`. It clears whenever `locked_s`=0.
- PLL_RST: stays exactly `PLL_RST_CYCLES` cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - If `stab` reaches `LOCK_STABLE_CYCLES`, go to DIV_SETTLE.
  - Otherwise, if `cnt` reaches `LOCK_TIMEOUT_CYCLES`: go to FAULT if `retries`==`MAX_RETRIES`, else increment `retries` and go to PLL_RST.
  - Stable completion wins over timeout in the same cycle.
- DIV_SETTLE: stays exactly `DIV_SETTLE_CYCLES` cycles, then goes to RUN.
- Lock loss: `locked_s`=0 in DIV_SETTLE or RUN goes to PLL_RST, increments `lock_losses` (saturates at 255) and clears `retries`.
- FAULT: holds until `restart` or `rst`.
- `restart` in any state goes to PLL_RST and clears `retries` and `fault`. `lock_losses` is not cleared.
- Priority: `rst` > `restart` > lock loss > normal transitions.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - state = PLL_RST, `cnt` = 0, `stab` = 0
  - `pll_rst` = `div_rst` = `video_rst` = 1
  - `ready` = 0, `fault` = 0, `retries` = 0, `lock_losses` = 0
- `rst` mid-sequence aborts immediately and behaves as at power-up.
- Outputs change on the clock edge that enters a state. No combinational path from any input to any output.
- `locked` to `locked_s` latency: 2 cycles. A lock drop reaches the outputs after 3 edges: `ready` falls and `pll_rst` rises.
- Nominal sequence with `locked` already high and stable, taking the first cycle after `rst` release as cycle 0:
  - `pll_rst` falls at cycle `PLL_RST_CYCLES`.
  - `div_rst` falls `LOCK_STABLE_CYCLES` cycles later.
  - `video_rst` falls and `ready` rises `DIV_SETTLE_CYCLES` cycles after that.
- FAULT is entered after (`MAX_RETRIES`+1) × (`PLL_RST_CYCLES`+`LOCK_TIMEOUT_CYCLES`) cycles with no lock.

## Structure
- Package `hdmi_clk_pkg`: state encoding constants and the default cycle parameters.
- One sub-module: `sync_2ff` (reset-clearable 2-flop synchronizer) for `locked`.
- The FSM and counters are inline in `hdmi_clk_ctrl`.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=64, `DIV_SETTLE_CYCLES`=4, `MAX_RETRIES`=2.

- **Nominal:** `locked`=1 constantly, release `rst` at cycle 0 → `pll_rst` falls at 4, `div_rst` at 12, `video_rst` falls and `ready` rises at 16; `retries`=0.
- **Glitchy lock:** `locked` pulses low 1 cycle at WAIT_LOCK cycle 5 → stable count restarts, `div_rst` falls 8 cycles after `locked_s` returns high.
- **No lock:** `locked`=0 → three WAIT_LOCK windows with `retries` 0,1,2, `fault`=1 at cycle 204, `pll_rst`=1 held; `restart` pulse → PLL_RST, `fault`=0, `retries`=0.
- **Lock loss in RUN:** drop `locked` for 1 cycle → `ready` falls 3 edges later, `lock_losses`=1, full sequence repeats, `ready` returns.
- **Simultaneous events:** `restart` and `rst` together in RUN → reset values. `restart` during DIV_SETTLE with `locked` low → PLL_RST with `lock_losses` unchanged.
